// File: rtl/proj_lut_eval_pkg.sv
// -----------------------------------------------------------------------------
// proj_lut_pkg
//
// Shared definitions for the projection LUT evaluator and the code that checks
// it.
//   N_IN_DEF / N_OUT_DEF : default number of function inputs and outputs.
//   PROJ_MAX_W           : widest address proj_apply can handle.
//   proj_word_t          : fixed-width carrier type for proj_apply. Callers
//                          zero-extend into it and truncate the result back
//                          to their own width.
//   proj_apply()         : forces every masked input bit to its value bit.
//                          Unmasked bits pass through unchanged.
// -----------------------------------------------------------------------------
package proj_lut_pkg;

    localparam int N_IN_DEF   = 6;
    localparam int N_OUT_DEF  = 1;
    localparam int PROJ_MAX_W = 32;

    typedef logic [PROJ_MAX_W-1:0] proj_word_t;

    // Computes the D-reduced address.
    // Bits with mask=1 come from val; all other bits come from x.
    function automatic proj_word_t proj_apply(input proj_word_t x,
                                              input proj_word_t mask,
                                              input proj_word_t val);
        return (x & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/proj_lut_eval_ram.sv
// -----------------------------------------------------------------------------
// proj_lut_ram
//
// Truth table holding 2^N_IN rows of N_OUT bits each. It has:
//   - one write port,
//   - one registered read port,
//   - a synchronous reset that clears every row and the read register.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   we     in   write strobe
//   waddr  in   row to write
//   wdata  in   row contents
//   re     in   read enable. rdata only changes on cycles where re is high.
//   raddr  in   row to read
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module proj_lut_ram
    import proj_lut_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N_IN-1:0]  waddr,
    input  logic [N_OUT-1:0] wdata,
    input  logic             re,
    input  logic [N_IN-1:0]  raddr,
    output logic [N_OUT-1:0] rdata
);

    localparam int DEPTH = 1 << N_IN;

    logic [N_OUT-1:0] mem [DEPTH];

    // rdata doubles as the output register of the evaluator. Holding it
    // whenever re is low is what keeps the result stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/proj_lut_eval.sv
// -----------------------------------------------------------------------------
// proj_lut_eval
//
// Two-stage pipelined evaluator for N_OUT Boolean functions of N_IN inputs.
//   - The functions come from a runtime-loadable truth table.
//   - A programmable projection forces selected inputs to constants before
//     the lookup.
//   - Pipeline stages:
//       S1 registers the projected address.
//       S2 registers the table row (out_y) and the address (out_x).
//   - Valid/ready on both sides with a full stall.
//   - Config writes are only accepted when the pipeline is empty.
//
// Optional build macro: PROJ_LUT_EVAL_CNT_EN.
// When defined, this adds:
//   - eval_cnt : a saturating count of output handshakes,
//   - cnt_clr  : a synchronous clear for eval_cnt.
//
// Ports
//   clk, rst              clock / synchronous active-high reset
//   cfg_we/addr/data      truth-table write port
//   cfg_ready             high when a table or projection write is accepted
//   proj_we/mask/val      projection register update
//   in_valid/ready/x      input vector handshake
//   out_valid/ready/y/x   result handshake: out_y = table row, out_x = address
//   cnt_clr, eval_cnt     (PROJ_LUT_EVAL_CNT_EN only) counter clear / value
// -----------------------------------------------------------------------------
module proj_lut_eval
    import proj_lut_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             proj_we,
    input  logic [N_IN-1:0]  proj_mask,
    input  logic [N_IN-1:0]  proj_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y,
    output logic [N_IN-1:0]  out_x
`ifdef PROJ_LUT_EVAL_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] eval_cnt
`endif
);

    logic            s1_valid;
    logic            s2_valid;
    logic [N_IN-1:0] s1_addr;
    logic [N_IN-1:0] mask_q;
    logic [N_IN-1:0] val_q;
    logic [N_IN-1:0] next_addr;
    logic            s1_adv;
    logic            s2_adv;
    logic            cfg_busy;
    logic            in_fire;
    logic            rd_en;

    // Handshake logic.
    //   - A stage advances when it is empty or its downstream stage advances.
    //   - cfg_ready requires an empty pipeline, so a table or projection
    //     write can never change the result of a vector already in flight.
    //   - A config write takes priority over an input vector in the same
    //     cycle.
    always_comb begin
        s2_adv    = !s2_valid || out_ready;
        s1_adv    = !s1_valid || s2_adv;
        cfg_ready = !s1_valid && !s2_valid && !rst;
        cfg_busy  = (cfg_we || proj_we) && cfg_ready;
        in_ready  = s1_adv && !cfg_busy && !rst;
        in_fire   = in_valid && in_ready;
        rd_en     = s2_adv && s1_valid;
        next_addr = N_IN'(proj_apply(PROJ_MAX_W'(in_x),
                                     PROJ_MAX_W'(mask_q),
                                     PROJ_MAX_W'(val_q)));
    end

    // Pipeline valid bits, S1 address, out_x and the projection registers.
    // out_x is only loaded together with the table read so that it always
    // matches out_y. Both therefore hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_addr  <= '0;
            out_x    <= '0;
            mask_q   <= '0;
            val_q    <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_x <= s1_addr;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_addr <= next_addr;
                end
            end
            if (proj_we && cfg_ready) begin
                mask_q <= proj_mask;
                val_q  <= proj_val;
            end
        end
    end

    assign out_valid = s2_valid;

    proj_lut_ram #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && cfg_ready),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .re    (rd_en),
        .raddr (s1_addr),
        .rdata (out_y)
    );

`ifdef PROJ_LUT_EVAL_CNT_EN
    // Output handshake counter.
    //   - Sticks at all-ones instead of wrapping.
    //   - cnt_clr beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            eval_cnt <= '0;
        end else if (cnt_clr) begin
            eval_cnt <= '0;
        end else if (s2_valid && out_ready && (eval_cnt != '1)) begin
            eval_cnt <= eval_cnt + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the counter. Without the counter there is nothing
    // to build, so this block is intentionally empty.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_proj_lut_eval.sv
// -----------------------------------------------------------------------------
// tb_proj_lut_eval
//
// Directed bench for proj_lut_eval with N_IN=6, N_OUT=1 and CNT_W=4.
//
// A reference model runs alongside the directed tests:
//   - It keeps a model truth table and a model projection.
//   - It keeps an ordered queue of expected results.
//   - It is updated from the handshakes observed on each edge.
//   - Every cycle it is compared against the DUT outputs.
//
// The directed tests also compare against hand-computed literal results.
// The counter tests are compiled only when PROJ_LUT_EVAL_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_proj_lut_eval;
    import proj_lut_pkg::*;

    localparam int N_IN  = 6;
    localparam int N_OUT = 1;
    localparam int CNT_W = 4;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [N_IN-1:0]  cfg_addr;
    logic [N_OUT-1:0] cfg_data;
    logic             cfg_ready;
    logic             proj_we;
    logic [N_IN-1:0]  proj_mask;
    logic [N_IN-1:0]  proj_val;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_x;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_y;
    logic [N_IN-1:0]  out_x;
`ifdef PROJ_LUT_EVAL_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] eval_cnt;
`endif

    proj_lut_eval #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .proj_we   (proj_we),
        .proj_mask (proj_mask),
        .proj_val  (proj_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_x     (out_x)
`ifdef PROJ_LUT_EVAL_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .eval_cnt  (eval_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [N_IN-1:0]  x;
        logic [N_OUT-1:0] y;
    } exp_t;

    logic [N_OUT-1:0] m_table [DEPTH];
    logic [N_IN-1:0]  m_mask;
    logic [N_IN-1:0]  m_val;
    exp_t             q[$];
    int               m_cnt;
    bit               prev_hold;
    logic [N_IN-1:0]  prev_x;
    logic [N_OUT-1:0] prev_y;
    int               last_out_edge;

    // Runs at each negedge, in two steps:
    //   1. Compare the current outputs against the model.
    //   2. Apply the handshakes that the next posedge will act on.
    always @(negedge clk) begin
        logic [N_IN-1:0] a;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_table[i] = '0;
            m_mask    = '0;
            m_val     = '0;
            m_cnt     = 0;
            prev_hold = 1'b0;
            q.delete();
        end else begin
            check("mon_cfg_ready", 32'(cfg_ready), 32'(q.size() == 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL mon_unexpected: got out_x %0h with no expected result", out_x);
                end else begin
                    check("mon_out_x", 32'(out_x), 32'(q[0].x));
                    check("mon_out_y", 32'(out_y), 32'(q[0].y));
                end
            end
            if (prev_hold) begin
                check("mon_hold_valid", 32'(out_valid), 32'd1);
                check("mon_hold_x", 32'(out_x), 32'(prev_x));
                check("mon_hold_y", 32'(out_y), 32'(prev_y));
            end
`ifdef PROJ_LUT_EVAL_CNT_EN
            check("mon_eval_cnt", 32'(eval_cnt), 32'(m_cnt));
`endif
            prev_hold = out_valid && !out_ready;
            prev_x    = out_x;
            prev_y    = out_y;
`ifdef PROJ_LUT_EVAL_CNT_EN
            if (cnt_clr) m_cnt = 0;
            else if (out_valid && out_ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                last_out_edge = cyc + 1;
            end
            if (cfg_we && cfg_ready) m_table[cfg_addr] = cfg_data;
            if (proj_we && cfg_ready) begin
                m_mask = proj_mask;
                m_val  = proj_val;
            end
            if (in_valid && in_ready) begin
                a = N_IN'(proj_apply(PROJ_MAX_W'(in_x), PROJ_MAX_W'(m_mask), PROJ_MAX_W'(m_val)));
                q.push_back('{x: a, y: m_table[a]});
            end
        end
    end

    // ---------------- directed tasks ----------------
    task automatic applyStimulus(input logic [N_IN-1:0] x);
        int n = 0;
        in_x     = x;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [N_IN-1:0] ex, input logic [N_OUT-1:0] ey);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_x"}, 32'(out_x), 32'(ex));
        check({name, "_y"}, 32'(out_y), 32'(ey));
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int first_acc;
        int accepted;
        logic [N_IN-1:0] r6;
        logic [N_IN-1:0] bx;

        // Initial input values; reset is held high.
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        proj_we   = 1'b0;
        proj_mask = '0;
        proj_val  = '0;
        in_valid  = 1'b1;
        in_x      = 6'h3F;
        out_ready = 1'b1;
`ifdef PROJ_LUT_EVAL_CNT_EN
        cnt_clr   = 1'b0;
`endif

        // Reset: in_ready must be low during reset; outputs cleared after it.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);

        // The table is cleared by reset, so any lookup returns 0.
        applyStimulus(6'h3F);
        checkOutput("clear_row", 6'h3F, 1'b0);

        // Load every row r with parity(r), including the last row 63.
        cfg_we = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            r6       = 6'(r);
            cfg_addr = r6;
            cfg_data = ^r6;
            tick();
        end
        cfg_we = 1'b0;

        // Stream 0..63 back to back and measure the handshake span.
        first_acc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_x     = 6'(i);
            in_valid = 1'b1;
            #1;
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            tick();
            if (i == 0) first_acc = cyc;
        end
        in_valid = 1'b0;
        drain("stream_drain");
        check("stream_span", 32'(last_out_edge - first_acc), 32'd65);

        // Hand-computed parity lookups.
        applyStimulus(6'h07);
        checkOutput("parity_07", 6'h07, 1'b1);
        applyStimulus(6'h24);
        checkOutput("parity_24", 6'h24, 1'b0);

        // Projection mask 000011, val 000001: 0x2E maps to 0x2D (parity 0).
        proj_we   = 1'b1;
        proj_mask = 6'b000011;
        proj_val  = 6'b000001;
        tick();
        proj_we = 1'b0;
        applyStimulus(6'h2E);
        checkOutput("proj_2e", 6'h2D, 1'b0);

        // Mask all ones: every vector looks up row proj_val (0x2A, parity 1).
        proj_we   = 1'b1;
        proj_mask = 6'h3F;
        proj_val  = 6'h2A;
        tick();
        proj_we = 1'b0;
        applyStimulus(6'h00);
        checkOutput("proj_all", 6'h2A, 1'b1);
        proj_we   = 1'b1;
        proj_mask = '0;
        proj_val  = '0;
        tick();
        proj_we = 1'b0;

        // Backpressure: at most two vectors are accepted, then in_ready drops.
        out_ready = 1'b0;
        accepted  = 0;
        bx        = 6'h10;
        for (int k = 0; k < 5; k++) begin
            in_x     = bx;
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                accepted++;
                bx = bx + 6'd1;
            end
            tick();
        end
        check("bp_accepted", 32'(accepted), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_first", 6'h10, 1'b1);
        checkOutput("bp_second", 6'h11, 1'b0);
        drain("bp_drain");

        // A config write while the pipeline is full is held off until it drains.
        out_ready = 1'b0;
        applyStimulus(6'h20);
        applyStimulus(6'h21);
        cfg_we   = 1'b1;
        cfg_addr = 6'h3F;
        cfg_data = 1'b1;
        #1;
        check("cfg_ready_full", 32'(cfg_ready), 32'd0);
        tick();
        tick();
        out_ready = 1'b1;
        n = 0;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        in_x     = 6'h3F;
        in_valid = 1'b1;
        #1;
        check("cfg_win_ready", 32'(cfg_ready), 32'd1);
        check("cfg_win_in_ready", 32'(in_ready), 32'd0);
        tick();
        cfg_we = 1'b0;
        applyStimulus(6'h3F);
        checkOutput("row63_new", 6'h3F, 1'b1);
        applyStimulus(6'h00);
        checkOutput("row0_nowrap", 6'h00, 1'b0);

        // Reset mid-stream discards in-flight vectors and clears the table.
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_x = 6'(k);
            tick();
        end
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
`ifdef PROJ_LUT_EVAL_CNT_EN
        check("midrst_cnt", 32'(eval_cnt), 32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(6'h07);
        checkOutput("postrst_cleared", 6'h07, 1'b0);

`ifdef PROJ_LUT_EVAL_CNT_EN
        // 20 more handshakes on top of the previous one saturate at 4'hF.
        for (int k = 0; k < 20; k++) applyStimulus(6'(k));
        drain("cnt_drain");
        check("cnt_saturated", 32'(eval_cnt), 32'hF);

        // cnt_clr together with a handshake wins.
        applyStimulus(6'h01);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr_hs", 32'(eval_cnt), 32'd0);

        // Reset mid-stream clears both out_valid and the counter.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_x = 6'(k);
            tick();
        end
        rst = 1'b1;
        tick();
        check("cnt_rst_valid", 32'(out_valid), 32'd0);
        check("cnt_rst_cnt", 32'(eval_cnt), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
`endif

        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
